// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, core count and
// core index values.
package dmem_pkg;

    localparam int NCORE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] CORE1 = 2'd0;
    localparam logic [1:0] CORE2 = 2'd1;
    localparam logic [1:0] CORE3 = 2'd2;
    localparam logic [1:0] CORE4 = 2'd3;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational 4-way round-robin pick; the search starts one past the last grant.
module rr_arbiter4
    import dmem_pkg::*;
(
    input  logic [NCORE-1:0] req_i,
    input  logic [1:0]       last_i,
    output logic [1:0]       grant_o,
    output logic             valid_o
);

    logic [1:0] idx_s;

    // Walk from lowest to highest priority so the nearest requester overwrites last.
    always_comb begin
        grant_o = 2'd0;
        valid_o = 1'b0;
        idx_s   = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx_s   = last_i + 2'(i);
            grant_o = req_i[idx_s] ? idx_s : grant_o;
            valid_o = valid_o | req_i[idx_s];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port DRAM between four cores, serving one load/store at a
// time in round-robin order with a one-cycle completion pulse per core.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              coreS_1,
    input  logic              coreS_2,
    input  logic              coreS_3,
    input  logic              coreS_4,
    input  logic              dREAD_1,
    input  logic              dREAD_2,
    input  logic              dREAD_3,
    input  logic              dREAD_4,
    input  logic              dWRITE_1,
    input  logic              dWRITE_2,
    input  logic              dWRITE_3,
    input  logic              dWRITE_4,
    input  logic [AWIDTH-1:0] ADDR_1,
    input  logic [AWIDTH-1:0] ADDR_2,
    input  logic [AWIDTH-1:0] ADDR_3,
    input  logic [AWIDTH-1:0] ADDR_4,
    input  logic [WIDTH-1:0]  WDATA_1,
    input  logic [WIDTH-1:0]  WDATA_2,
    input  logic [WIDTH-1:0]  WDATA_3,
    input  logic [WIDTH-1:0]  WDATA_4,
    input  logic [WIDTH-1:0]  DATA_IN,
    output logic              rEN,
    output logic              wEN,
    output logic [AWIDTH-1:0] ADDR_OUT,
    output logic [WIDTH-1:0]  DATA_OUT,
    output logic [WIDTH-1:0]  RDATA_1,
    output logic [WIDTH-1:0]  RDATA_2,
    output logic [WIDTH-1:0]  RDATA_3,
    output logic [WIDTH-1:0]  RDATA_4,
    output logic              dmemAV1,
    output logic              dmemAV2,
    output logic              dmemAV3,
    output logic              dmemAV4
);

    logic [NCORE-1:0]  rd_s;
    logic [NCORE-1:0]  wr_s;
    logic [NCORE-1:0]  req_s;
    logic [AWIDTH-1:0] addr_s  [NCORE];
    logic [WIDTH-1:0]  wdata_s [NCORE];
    logic [1:0]        pick_s;
    logic              valid_s;

    state_t            state_q;
    logic [1:0]        grant_q;
    logic [1:0]        last_q;
    logic              wr_q;
    logic              ren_q;
    logic              wen_q;
    logic [AWIDTH-1:0] addr_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  rdata_q [NCORE];
    logic [NCORE-1:0]  av_q;

    assign rd_s  = {dREAD_4, dREAD_3, dREAD_2, dREAD_1};
    assign wr_s  = {dWRITE_4, dWRITE_3, dWRITE_2, dWRITE_1};
    // Inactive cores are masked only here, at grant time.
    assign req_s = (rd_s | wr_s) & ~{coreS_4, coreS_3, coreS_2, coreS_1};

    assign addr_s[0]  = ADDR_1;
    assign addr_s[1]  = ADDR_2;
    assign addr_s[2]  = ADDR_3;
    assign addr_s[3]  = ADDR_4;
    assign wdata_s[0] = WDATA_1;
    assign wdata_s[1] = WDATA_2;
    assign wdata_s[2] = WDATA_3;
    assign wdata_s[3] = WDATA_4;

    rr_arbiter4 u_rr (
        .req_i   (req_s),
        .last_i  (last_q),
        .grant_o (pick_s),
        .valid_o (valid_s)
    );

    // Transaction FSM with the pointer and all registered DRAM/core outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            grant_q <= CORE1;
            last_q  <= CORE4;
            wr_q    <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            av_q    <= '0;
            for (int i = 0; i < NCORE; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_s) begin
                        grant_q <= pick_s;
                        last_q  <= pick_s;
                        addr_q  <= addr_s[pick_s];
                        data_q  <= wdata_s[pick_s];
                        wr_q    <= wr_s[pick_s];
                        ren_q   <= ~wr_s[pick_s];
                        wen_q   <= wr_s[pick_s];
                        state_q <= ISSUE;
                    end else begin
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end
                end
                ISSUE: begin
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!wr_q) begin
                        rdata_q[grant_q] <= DATA_IN;
                    end
                    av_q    <= 4'b0001 << grant_q;
                    state_q <= DONE;
                end
                DONE: begin
                    av_q    <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                    av_q    <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rEN      = ren_q;
    assign wEN      = wen_q;
    assign ADDR_OUT = addr_q;
    assign DATA_OUT = data_q;
    assign RDATA_1  = rdata_q[0];
    assign RDATA_2  = rdata_q[1];
    assign RDATA_3  = rdata_q[2];
    assign RDATA_4  = rdata_q[3];
    assign dmemAV1  = av_q[0];
    assign dmemAV2  = av_q[1];
    assign dmemAV3  = av_q[2];
    assign dmemAV4  = av_q[3];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected transactions are queued when
// requests are raised and retired against DRAM issues and completion pulses.
module tb_dmem_arbiter;

    logic       Clk;
    logic       Rst_n;
    logic [3:0] cores;
    logic [3:0] dread;
    logic [3:0] dwrite;
    logic [7:0] addr_t  [4];
    logic [7:0] wdata_t [4];
    logic [7:0] DATA_IN;
    logic       rEN, wEN;
    logic [7:0] ADDR_OUT, DATA_OUT;
    logic [7:0] rdata_t [4];
    logic       av1, av2, av3, av4;
    logic [3:0] av;

    assign av = {av4, av3, av2, av1};

    dmem_arbiter #(.WIDTH(8), .AWIDTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .coreS_1(cores[0]), .coreS_2(cores[1]), .coreS_3(cores[2]), .coreS_4(cores[3]),
        .dREAD_1(dread[0]), .dREAD_2(dread[1]), .dREAD_3(dread[2]), .dREAD_4(dread[3]),
        .dWRITE_1(dwrite[0]), .dWRITE_2(dwrite[1]), .dWRITE_3(dwrite[2]), .dWRITE_4(dwrite[3]),
        .ADDR_1(addr_t[0]), .ADDR_2(addr_t[1]), .ADDR_3(addr_t[2]), .ADDR_4(addr_t[3]),
        .WDATA_1(wdata_t[0]), .WDATA_2(wdata_t[1]), .WDATA_3(wdata_t[2]), .WDATA_4(wdata_t[3]),
        .DATA_IN(DATA_IN), .rEN(rEN), .wEN(wEN), .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT),
        .RDATA_1(rdata_t[0]), .RDATA_2(rdata_t[1]), .RDATA_3(rdata_t[2]), .RDATA_4(rdata_t[3]),
        .dmemAV1(av1), .dmemAV2(av2), .dmemAV3(av3), .dmemAV4(av4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Unwritten DRAM locations read back a fixed function of their address.
    function automatic logic [7:0] dram_init(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    logic [7:0] mem     [256];
    bit         written [256];

    // DRAM model: enables sampled at the edge, read data one cycle later.
    always @(posedge Clk) begin
        if (wEN) begin
            mem[ADDR_OUT]     <= DATA_OUT;
            written[ADDR_OUT] <= 1'b1;
        end
        if (rEN) begin
            DATA_IN <= written[ADDR_OUT] ? mem[ADDR_OUT] : dram_init(ADDR_OUT);
        end
    end

    typedef struct {
        int         core;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] model_rd [4];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         issue_cyc = -1;
    int         prev_issue = -1;
    bit         chk_clear = 1'b0;
    bit         chk_spacing = 1'b0;
    logic [3:0] prev_av = 4'b0000;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input int core, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] rd);
        exp_t e;
        e.core = core; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    // One cycle: sample at the falling edge, retire scoreboard entries, drop finished requests.
    task automatic step();
        exp_t e;
        @(negedge Clk);
        cyc++;
        if (Rst_n) begin
            if (chk_clear) begin
                check_eq("en_single_cycle", {30'd0, rEN, wEN}, 0);
                chk_clear = 1'b0;
            end else if (rEN || wEN) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_issue", 1, 0);
                end else begin
                    e = exp_q[0];
                    check_eq("issue_wen", int'(wEN), int'(e.wr));
                    check_eq("issue_ren", int'(rEN), int'(!e.wr));
                    check_eq("issue_addr", int'(ADDR_OUT), int'(e.addr));
                    if (e.wr) check_eq("issue_wdata", int'(DATA_OUT), int'(e.wdata));
                    if (chk_spacing && prev_issue >= 0) check_eq("grant_spacing", cyc - prev_issue, 4);
                    prev_issue = cyc;
                    issue_cyc  = cyc;
                    chk_clear  = 1'b1;
                end
            end
            if (av != 4'b0000) begin
                check_eq("av_onehot", $countones(av), 1);
                check_eq("av_gap", int'(prev_av), 0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_av", int'(av), 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("av_core", int'(av), 1 << e.core);
                    check_eq("av_latency", cyc - issue_cyc, 2);
                    if (!e.wr) model_rd[e.core] = e.rdata;
                    check_eq("rdata", int'(rdata_t[e.core]), int'(model_rd[e.core]));
                end
                for (int k = 0; k < 4; k++) begin
                    if (av[k]) begin
                        dread[k]  = 1'b0;
                        dwrite[k] = 1'b0;
                    end
                end
            end
            prev_av = av;
        end else begin
            prev_av = 4'b0000;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_timeout", exp_q.size(), 0);
        repeat (6) step();
    endtask

    task automatic do_reset();
        Rst_n  = 1'b0;
        dread  = 4'b0000;
        dwrite = 4'b0000;
        cores  = 4'b0000;
        repeat (3) step();
        exp_q.delete();
        chk_clear = 1'b0;
        prev_issue = -1;
        for (int k = 0; k < 4; k++) model_rd[k] = 8'h00;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            addr_t[k]  = 8'h00;
            wdata_t[k] = 8'h00;
        end
        do_reset();
        check_eq("rst_ren", int'(rEN), 0);
        check_eq("rst_wen", int'(wEN), 0);
        check_eq("rst_addr", int'(ADDR_OUT), 0);
        check_eq("rst_dout", int'(DATA_OUT), 0);
        check_eq("rst_av", int'(av), 0);
        for (int k = 0; k < 4; k++) check_eq("rst_rdata", int'(rdata_t[k]), 0);
        Rst_n = 1'b1;

        // 1: single read by core 2
        addr_t[1] = 8'h10;
        dread[1]  = 1'b1;
        push(1, 1'b0, 8'h10, 8'h00, 8'hA5);
        wait_done(20);
        check_eq("t1_rdata2", int'(rdata_t[1]), 8'hA5);

        // 2: all four read at once, order 1..4 at 4-cycle spacing
        do_reset();
        Rst_n = 1'b1;
        chk_spacing = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_t[k] = 8'(k + 1);
            push(k, 1'b0, 8'(k + 1), 8'h00, dram_init(8'(k + 1)));
        end
        dread = 4'b1111;
        wait_done(40);
        chk_spacing = 1'b0;

        // 3: core 3 writes 0x3C to 0x22, core 1 reads it back
        addr_t[2] = 8'h22; wdata_t[2] = 8'h3C; dwrite[2] = 1'b1;
        push(2, 1'b1, 8'h22, 8'h3C, 8'h00);
        wait_done(20);
        addr_t[0] = 8'h22; dread[0] = 1'b1;
        push(0, 1'b0, 8'h22, 8'h00, 8'h3C);
        wait_done(20);
        check_eq("t3_rdata1", int'(rdata_t[0]), 8'h3C);

        // 4: inactive core 4 is masked until it becomes active
        cores[3] = 1'b1; addr_t[3] = 8'h44; dread[3] = 1'b1;
        addr_t[0] = 8'h41; dread[0] = 1'b1;
        push(0, 1'b0, 8'h41, 8'h00, dram_init(8'h41));
        wait_done(20);
        repeat (20) step();
        check_eq("t4_core4_pending", int'(dread[3]), 1);
        cores[3] = 1'b0;
        push(3, 1'b0, 8'h44, 8'h00, dram_init(8'h44));
        wait_done(20);

        // 5: read+write together is a write, RDATA_2 keeps its earlier value
        addr_t[1] = 8'h30; wdata_t[1] = 8'h77; dread[1] = 1'b1; dwrite[1] = 1'b1;
        push(1, 1'b1, 8'h30, 8'h77, 8'h00);
        wait_done(20);
        check_eq("t5_rdata2_kept", int'(rdata_t[1]), int'(dram_init(8'h02)));

        // 6: reset during WAIT of a read
        addr_t[0] = 8'h05; dread[0] = 1'b1;
        push(0, 1'b0, 8'h05, 8'h00, dram_init(8'h05));
        issue_cyc = -1;
        for (int n = 0; n < 20 && issue_cyc != cyc; n++) step();
        check_eq("t6_issued", int'(issue_cyc == cyc), 1);
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        check_eq("t6_ren", int'(rEN), 0);
        check_eq("t6_wen", int'(wEN), 0);
        check_eq("t6_av", int'(av), 0);
        check_eq("t6_rdata1", int'(rdata_t[0]), 0);
        exp_q.delete();
        chk_clear = 1'b0;
        for (int k = 0; k < 4; k++) model_rd[k] = 8'h00;
        repeat (2) step();
        check_eq("t6_av_held", int'(av), 0);
        addr_t[1] = 8'h06; dread[1] = 1'b1;
        push(0, 1'b0, 8'h05, 8'h00, dram_init(8'h05));
        push(1, 1'b0, 8'h06, 8'h00, dram_init(8'h06));
        Rst_n = 1'b1;
        wait_done(30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
